ext_unit_pipe: RTL

//  - Parametrised, pipelined bit-extension unit; successor to the fixed 1->32 zero-extender.
//  - Widens an IN_W operand to OUT_W in one of four modes:

---
 rtl/ext_unit_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/ext_unit_pipe.sv
// Pipelined operand extender (zero / sign / upper / bool) with a 2-entry valid/ready output buffer.
// Optional macro EXT_COUNT_EN adds the CNT_W-bit xfer_count port counting accepted operands.
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
`ifdef EXT_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef EXT_COUNT_EN
    ,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] ext_result;
    logic             push;
    logic             pop;

    logic [1:0]       count_q, count_d;
    logic [OUT_W-1:0] head_q,  head_d;
    logic [OUT_W-1:0] tail_q,  tail_d;

    // Extension is done before storage so out_data comes straight from a flop.
    always_comb begin
        ext_result = '0;
        case (in_mode)
            2'b00:   ext_result = OUT_W'(in_data);
            2'b01:   ext_result = OUT_W'($signed(in_data));
            2'b10:   ext_result = OUT_W'(in_data) << PAD_W;
            default: ext_result = OUT_W'(|in_data);
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = ext_result;
                end else begin
                    tail_d = ext_result;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push can only coincide with pop at count 1: the new result replaces the head.
                if (count_q == 2'd1) begin
                    head_d = ext_result;
                end else begin
                    head_d = tail_q;
                    tail_d = ext_result;
                end
            end
            default: ;
        endcase
    end

`ifdef EXT_COUNT_EN
    logic [CNT_W-1:0] xfer_q, xfer_d;

    always_comb begin
        xfer_d = xfer_q;
        if (push) begin
            xfer_d = xfer_q + CNT_W'(1);
        end
    end

    assign xfer_count = xfer_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_q <= '0;
        end else begin
            xfer_q <= xfer_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
